// File: rtl/ascii_num_parser.sv
// ascii_num_parser: turns a stream of ASCII hex characters into NUM_W-bit values.
// A field is a run of hex digits ended by '_' (separator) or CR (end of frame).
// Each value goes out through a single-entry valid/ready output register.
// Optional build macro: ASCII_NUM_LOWERCASE_EN also accepts 'a'-'f' as digits.
module ascii_num_parser #(
    parameter int DATA_W     = 8,
    parameter int MAX_DIGITS = 4,
    parameter int NUM_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_W-1:0]  out_num,
    output logic              out_last,
    output logic              frame_done,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

    // Each digit fills exactly one nibble of the output value.
    generate
        if (NUM_W != 4 * MAX_DIGITS) begin : g_bad_width
            $error("ascii_num_parser: NUM_W must equal 4*MAX_DIGITS");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [NUM_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               out_valid_reg, out_valid_next;
    logic [NUM_W-1:0]   out_num_reg, out_num_next;
    logic               out_last_reg, out_last_next;
    logic               frame_done_reg, frame_done_next;
    logic               err_reg, err_next;

    logic               is_digit, is_sep, is_eol;
    logic [3:0]         nibble;
    logic               accept;

    // A full, unaccepted output register stalls the input; nothing is taken during reset.
    assign in_ready   = !rst && !(out_valid_reg && !out_ready);
    assign accept     = in_valid && in_ready;

    assign out_valid  = out_valid_reg;
    assign out_num    = out_num_reg;
    assign out_last   = out_last_reg;
    assign frame_done = frame_done_reg;
    assign err        = err_reg;

    // Classify the incoming character and extract its nibble value.
    always_comb begin
        is_digit = 1'b0;
        is_sep   = 1'b0;
        is_eol   = 1'b0;
        nibble   = 4'h0;
        if (in_data >= DATA_W'(8'h30) && in_data <= DATA_W'(8'h39)) begin
            is_digit = 1'b1;
            nibble   = 4'(in_data - DATA_W'(8'h30));
        end else if (in_data >= DATA_W'(8'h41) && in_data <= DATA_W'(8'h46)) begin
            is_digit = 1'b1;
            nibble   = 4'(in_data - DATA_W'(8'h37));
`ifdef ASCII_NUM_LOWERCASE_EN
        end else if (in_data >= DATA_W'(8'h61) && in_data <= DATA_W'(8'h66)) begin
            is_digit = 1'b1;
            nibble   = 4'(in_data - DATA_W'(8'h57));
`endif
        end else if (in_data == DATA_W'(8'h5F)) begin
            is_sep = 1'b1;
        end else if (in_data == DATA_W'(8'h0D)) begin
            is_eol = 1'b1;
        end
    end

    // Next-state, accumulator, output register and pulse logic.
    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        out_valid_next  = out_valid_reg;
        out_num_next    = out_num_reg;
        out_last_next   = out_last_reg;
        frame_done_next = 1'b0;
        err_next        = 1'b0;

        // Consumer took the current value; may be overridden by a back-to-back load.
        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            // CR always ends the frame, whatever the field state.
            frame_done_next = is_eol;
            unique case (state_reg)
                IDLE: begin
                    if (is_digit) begin
                        acc_next   = NUM_W'(nibble);
                        cnt_next   = CNT_W'(1);
                        state_next = ACCUM;
                    end else if (!is_sep && !is_eol) begin
                        err_next   = 1'b1;
                        state_next = DISCARD;
                    end
                end
                ACCUM: begin
                    if (is_digit) begin
                        if (cnt_reg == CNT_W'(MAX_DIGITS)) begin
                            err_next   = 1'b1;
                            state_next = DISCARD;
                        end else begin
                            acc_next = {acc_reg[NUM_W-5:0], nibble};
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end else if (is_sep || is_eol) begin
                        out_valid_next = 1'b1;
                        out_num_next   = acc_reg;
                        out_last_next  = is_eol;
                        acc_next       = '0;
                        cnt_next       = '0;
                        state_next     = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_sep || is_eol) begin
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_num_reg    <= '0;
            out_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            out_valid_reg  <= out_valid_next;
            out_num_reg    <= out_num_next;
            out_last_reg   <= out_last_next;
            frame_done_reg <= frame_done_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: tb/tb_ascii_num_parser.sv
// Self-checking bench for ascii_num_parser: directed scenarios with literal
// expectations plus randomized traffic against a field-level reference model.
module tb_ascii_num_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_num;
    logic        out_last;
    logic        frame_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: field kept as a list of digit values.
    int  m_mode = 0;       // 0 between fields, 1 collecting digits, 2 dropping a bad field
    int  m_digs[$];
    bit  m_ov = 0;
    int  m_num = 0;
    bit  m_last = 0;
    bit  m_err = 0;
    bit  m_fd = 0;

    // Observed traffic for the directed scenarios.
    int  captured[$];
    int  err_cnt = 0;
    int  fd_cnt  = 0;

    always #5 clk = ~clk;

    ascii_num_parser #(.DATA_W(8), .MAX_DIGITS(4), .NUM_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_num(out_num), .out_last(out_last), .frame_done(frame_done), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dval(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
`ifdef ASCII_NUM_LOWERCASE_EN
        if (c >= "a" && c <= "f") return int'(c) - 87;
`endif
        return -1;
    endfunction

    // One clock cycle: drive, check in_ready, advance model, check outputs.
    task automatic cycle(input bit v, input byte d, input bit r, input bit rs, output bit accepted);
        bit exp_rdy;
        bit n_ov, n_last, n_err, n_fd;
        int n_num, dv, val;
        in_valid = v; in_data = d; out_ready = r; rst = rs;
        #1;
        exp_rdy = !rs && !(m_ov && !r);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        if (!rs && out_valid && r) captured.push_back(int'({out_last, out_num}));
        accepted = v && exp_rdy;

        n_ov = m_ov; n_num = m_num; n_last = m_last; n_err = 0; n_fd = 0;
        if (m_ov && r) n_ov = 0;
        if (rs) begin
            n_ov = 0; n_num = 0; n_last = 0;
            m_mode = 0; m_digs.delete();
        end else if (accepted) begin
            dv = dval(d);
            n_fd = (d == 8'h0D);
            if (m_mode == 0) begin
                if (dv >= 0) begin m_digs.delete(); m_digs.push_back(dv); m_mode = 1; end
                else if (d != "_" && d != 8'h0D) begin n_err = 1; m_mode = 2; end
            end else if (m_mode == 1) begin
                if (dv >= 0) begin
                    if (m_digs.size() < 4) m_digs.push_back(dv);
                    else begin n_err = 1; m_mode = 2; end
                end else if (d == "_" || d == 8'h0D) begin
                    val = 0;
                    foreach (m_digs[i]) val = val * 16 + m_digs[i];
                    n_ov = 1; n_num = val; n_last = (d == 8'h0D);
                    m_mode = 0; m_digs.delete();
                end else begin
                    n_err = 1; m_mode = 2;
                end
            end else begin
                if (d == "_" || d == 8'h0D) m_mode = 0;
            end
        end

        @(posedge clk);
        #1;
        m_ov = n_ov; m_num = n_num; m_last = n_last; m_err = n_err; m_fd = n_fd;
        chk("out_valid", int'(out_valid), int'(m_ov));
        if (m_ov) begin
            chk("out_num", int'(out_num), m_num);
            chk("out_last", int'(out_last), int'(m_last));
        end
        chk("err", int'(err), int'(m_err));
        chk("frame_done", int'(frame_done), int'(m_fd));
        if (err) err_cnt++;
        if (frame_done) fd_cnt++;
    endtask

    // Offer one character, holding it until accepted (bounded).
    task automatic send(input byte c, input bit r);
        bit acc;
        for (int k = 0; k < 30; k++) begin
            cycle(1'b1, c, r, 1'b0, acc);
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    endtask

    task automatic clear_obs();
        captured.delete(); err_cnt = 0; fd_cnt = 0;
    endtask

    task automatic run_seq(input string s, input bit r);
        clear_obs();
        for (int i = 0; i < s.len(); i++) send(s[i], r);
        idle(4);
        $display("seq \"%s\": outputs=%0d err=%0d frame_done=%0d", s, captured.size(), err_cnt, fd_cnt);
    endtask

    task automatic expect_outs(input string name, input int n, input int v0, input int v1);
        chk({name, "_count"}, captured.size(), n);
        if (n > 0 && captured.size() > 0) chk({name, "_v0"}, captured[0], v0);
        if (n > 1 && captured.size() > 1) chk({name, "_v1"}, captured[1], v1);
    endtask

    initial begin
        bit acc;
        byte tbl[24];
        string chars;
        chars = "0123456789ABCDEFaf__\r\rGz";
        for (int i = 0; i < 24; i++) tbl[i] = chars[i];

        // Reset: in_ready low during reset, all outputs zero afterwards.
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        chk("rst_out_num", int'(out_num), 0);
        chk("rst_out_last", int'(out_last), 0);
        idle(1);
        chk("post_rst_in_ready", int'(in_ready), 1);

        run_seq("1A3F_", 1'b1);
        expect_outs("s1", 1, 32'h0_1A3F, 0);
        chk("s1_err", err_cnt, 0);

        run_seq("7\r", 1'b1);
        expect_outs("s2", 1, 32'h1_0007, 0);
        chk("s2_fd", fd_cnt, 1);

        run_seq("12345_9_", 1'b1);
        expect_outs("s3", 1, 32'h0_0009, 0);
        chk("s3_err", err_cnt, 1);

        run_seq("1G2_4_", 1'b1);
        expect_outs("s4", 1, 32'h0_0004, 0);
        chk("s4_err", err_cnt, 1);

        run_seq("__\r", 1'b1);
        expect_outs("s5", 0, 0, 0);
        chk("s5_fd", fd_cnt, 1);

        // Stall: "AB_" held in the output while "CD_" waits.
        clear_obs();
        send("A", 1'b0); send("B", 1'b0); send("_", 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, "C", 1'b0, 1'b0, acc);
            chk("stall_accept", int'(acc), 0);
        end
        chk("stall_num", int'(out_num), 16'h00AB);
        send("C", 1'b1); send("D", 1'b1); send("_", 1'b1);
        idle(4);
        $display("seq stall AB_/CD_: outputs=%0d", captured.size());
        expect_outs("s6", 2, 32'h0_00AB, 32'h0_00CD);

        run_seq("f_", 1'b1);
`ifdef ASCII_NUM_LOWERCASE_EN
        expect_outs("s7", 1, 32'h0_000F, 0);
        chk("s7_err", err_cnt, 0);
`else
        expect_outs("s7", 0, 0, 0);
        chk("s7_err", err_cnt, 1);
`endif

        // Reset in the middle of a field drops the partial value.
        clear_obs();
        send("1", 1'b1); send("2", 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        for (int i = 0; i < 2; i++) send(i == 0 ? 8'h33 : 8'h5F, 1'b1);
        idle(4);
        $display("seq 12<rst>3_: outputs=%0d", captured.size());
        expect_outs("s8", 1, 32'h0_0003, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 4) != 0, tbl[$urandom % 24], ($urandom % 3) != 0,
                  ($urandom % 400) == 0, acc);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
